// File: rtl/apb3_to_axi4_bridge_if.sv
// AXI4 bundle, all five channels; the Master modport drives requests, the Slave modport drives responses.
// Latency: none, wires only.
// Backpressure: standard AXI4 valid/ready on every channel.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/apb3_to_axi4_bridge.sv
// APB3 slave to AXI4 master bridge: each APB transfer becomes one single-beat AXI read or write.
// Latency: 3-cycle minimum APB access phase, plus one cycle per AXI wait cycle; one transaction outstanding.
// Backpressure: pready stays low until the AXI response returns; AXI valids hold until accepted.
// Optional: define APB3_TO_AXI4_SLVERR_EN to report AXI SLVERR/DECERR on pslverr.
module apb3_to_axi4_bridge #(
    parameter int                      APB3_ADDR_WIDTH = 32,
    parameter int                      APB3_DATA_WIDTH = 32,
    parameter int                      AXI_ID_WIDTH    = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID          = '0,
    parameter logic [2:0]              AXI_PROT        = 3'b010
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [APB3_ADDR_WIDTH-1:0] i_apb_paddr,
    input  logic                       i_apb_psel,
    input  logic                       i_apb_penable,
    input  logic                       i_apb_pwrite,
    input  logic [APB3_DATA_WIDTH-1:0] i_apb_pwdata,
    output logic [APB3_DATA_WIDTH-1:0] o_apb_prdata,
    output logic                       o_apb_pready,
    output logic                       o_apb_pslverr,
    axi4_if.Master                     axi4
);
    localparam int STRB_WIDTH = APB3_DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam logic [APB3_ADDR_WIDTH-1:0] ALIGN_MASK = ~APB3_ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [2:0] AXI_SIZE = 3'(LSB);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                     state;
    logic [APB3_ADDR_WIDTH-1:0] addr_q;
    logic [APB3_DATA_WIDTH-1:0] wdata_q;
    logic [APB3_DATA_WIDTH-1:0] prdata_q;
    logic                       aw_valid_q;
    logic                       w_valid_q;
    logic                       ar_valid_q;
    logic                       b_ready_q;
    logic                       r_ready_q;
    logic                       pready_q;
`ifdef APB3_TO_AXI4_SLVERR_EN
    logic                       pslverr_q;
`endif

    assign axi4.aw_id    = AXI_ID;
    assign axi4.aw_addr  = addr_q;
    assign axi4.aw_len   = 8'd0;
    assign axi4.aw_size  = AXI_SIZE;
    assign axi4.aw_burst = 2'b01;
    assign axi4.aw_lock  = 1'b0;
    assign axi4.aw_cache = 4'b0000;
    assign axi4.aw_prot  = AXI_PROT;
    assign axi4.aw_valid = aw_valid_q;

    assign axi4.w_data   = wdata_q;
    assign axi4.w_strb   = '1;
    assign axi4.w_last   = 1'b1;
    assign axi4.w_valid  = w_valid_q;
    assign axi4.b_ready  = b_ready_q;

    assign axi4.ar_id    = AXI_ID;
    assign axi4.ar_addr  = addr_q;
    assign axi4.ar_len   = 8'd0;
    assign axi4.ar_size  = AXI_SIZE;
    assign axi4.ar_burst = 2'b01;
    assign axi4.ar_lock  = 1'b0;
    assign axi4.ar_cache = 4'b0000;
    assign axi4.ar_prot  = AXI_PROT;
    assign axi4.ar_valid = ar_valid_q;
    assign axi4.r_ready  = r_ready_q;

    assign o_apb_prdata  = prdata_q;
    assign o_apb_pready  = pready_q;
`ifdef APB3_TO_AXI4_SLVERR_EN
    assign o_apb_pslverr = pslverr_q;
`else
    assign o_apb_pslverr = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            pready_q   <= 1'b0;
`ifdef APB3_TO_AXI4_SLVERR_EN
            pslverr_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_apb_psel && !i_apb_penable) begin
                        addr_q  <= i_apb_paddr & ALIGN_MASK;
                        wdata_q <= i_apb_pwdata;
                        if (i_apb_pwrite) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state      <= WR_ADDR_DATA;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state      <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W retire independently; move on once neither is still pending.
                    if (axi4.aw_ready) aw_valid_q <= 1'b0;
                    if (axi4.w_ready)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || axi4.aw_ready) && (!w_valid_q || axi4.w_ready)) begin
                        b_ready_q <= 1'b1;
                        state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi4.b_valid) begin
                        b_ready_q <= 1'b0;
                        pready_q  <= 1'b1;
`ifdef APB3_TO_AXI4_SLVERR_EN
                        pslverr_q <= axi4.b_resp[1];
`endif
                        state     <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (axi4.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi4.r_valid) begin
                        r_ready_q <= 1'b0;
                        prdata_q  <= axi4.r_data;
                        pready_q  <= 1'b1;
`ifdef APB3_TO_AXI4_SLVERR_EN
                        pslverr_q <= axi4.r_resp[1];
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
`ifdef APB3_TO_AXI4_SLVERR_EN
                    pslverr_q <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_to_axi4_bridge.sv
// Bench for apb3_to_axi4_bridge: APB master task, randomized-latency AXI slave and a transaction-level model.
// The slave/model process checks every AXI and APB output on each falling edge.
module tb_apb3_to_axi4_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    always #5 clk = ~clk;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    apb3_to_axi4_bridge dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_apb_paddr   (paddr),
        .i_apb_psel    (psel),
        .i_apb_penable (penable),
        .i_apb_pwrite  (pwrite),
        .i_apb_pwdata  (pwdata),
        .o_apb_prdata  (prdata),
        .o_apb_pready  (pready),
        .o_apb_pslverr (pslverr),
        .axi4          (axi)
    );

    int tests = 0;
    int fails = 0;

    // Per-transaction slave behaviour, chosen by the APB side before each setup phase.
    int          t_aw, t_w, t_b, t_ar, t_r;
    logic [1:0]  t_resp;
    logic [31:0] t_rdata;
    bit          force_stray;

    // Observed handshakes.
    int          n_aw, n_w, n_b, n_ar, n_r;
    logic [31:0] hs_aw_addr, hs_w_data, hs_ar_addr;
    bit          q_order[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit slverr_of(input logic [1:0] resp);
`ifdef APB3_TO_AXI4_SLVERR_EN
        return resp[1];
`else
        return 1'b0 & resp[0];
`endif
    endfunction

    // AXI slave plus reference model. Outputs are stable at the falling edge; readies/valids
    // driven here are sampled by the DUT on the following rising edge.
    initial begin : slave_model
        bit          busy, wr, aw_done, w_done, ar_done, rsp_done;
        bit          b_phase, r_phase, e_pready;
        logic [31:0] m_addr, m_wdata, m_rdata, last_rdata;
        logic [1:0]  m_resp;
        int          d_aw, d_w, d_b, d_ar, d_r, c_aw, c_w, c_b, c_ar, c_r;
        busy = 0; wr = 0; aw_done = 0; w_done = 0; ar_done = 0; rsp_done = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_resp = '0; last_rdata = '0;
        d_aw = 0; d_w = 0; d_b = 0; d_ar = 0; d_r = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        hs_aw_addr = '0; hs_w_data = '0; hs_ar_addr = '0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.b_valid = 0; axi.b_resp = 0; axi.b_id = 0;
        axi.r_valid = 0; axi.r_resp = 0; axi.r_id = 0; axi.r_data = 0; axi.r_last = 1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            b_phase  = busy && wr && aw_done && w_done && !rsp_done;
            r_phase  = busy && !wr && ar_done && !rsp_done;
            e_pready = busy && rsp_done;

            chk("aw_valid", 64'(axi.aw_valid), 64'(busy && wr && !aw_done));
            chk("w_valid",  64'(axi.w_valid),  64'(busy && wr && !w_done));
            chk("b_ready",  64'(axi.b_ready),  64'(b_phase));
            chk("ar_valid", 64'(axi.ar_valid), 64'(busy && !wr && !ar_done));
            chk("r_ready",  64'(axi.r_ready),  64'(r_phase));
            chk("pready",   64'(pready),       64'(e_pready));
            chk("pslverr",  64'(pslverr),      64'(e_pready && slverr_of(m_resp)));
            chk("prdata",   64'(prdata),       64'(last_rdata));
            if (busy && wr && !aw_done) begin
                chk("aw_addr", 64'(axi.aw_addr), 64'(m_addr));
                chk("aw_fields", 64'({axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock,
                                      axi.aw_cache, axi.aw_prot, axi.aw_id}),
                    64'({8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'b010, 4'd0}));
            end
            if (busy && wr && !w_done)
                chk("w_beat", 64'({axi.w_data, axi.w_strb, axi.w_last}), 64'({m_wdata, 4'hF, 1'b1}));
            if (busy && !wr && !ar_done) begin
                chk("ar_addr", 64'(axi.ar_addr), 64'(m_addr));
                chk("ar_fields", 64'({axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock,
                                      axi.ar_cache, axi.ar_prot, axi.ar_id}),
                    64'({8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'b010, 4'd0}));
            end

            axi.aw_ready = axi.aw_valid ? (c_aw >= d_aw) : 1'($urandom);
            axi.w_ready  = axi.w_valid  ? (c_w  >= d_w)  : 1'($urandom);
            axi.ar_ready = axi.ar_valid ? (c_ar >= d_ar) : 1'($urandom);
            axi.b_valid  = b_phase ? (c_b >= d_b) : (force_stray || $urandom_range(0, 3) == 0);
            axi.b_resp   = b_phase ? m_resp : 2'($urandom);
            axi.b_id     = 4'($urandom);
            axi.r_valid  = r_phase ? (c_r >= d_r) : (force_stray || $urandom_range(0, 3) == 0);
            axi.r_resp   = r_phase ? m_resp : 2'($urandom);
            axi.r_data   = r_phase ? m_rdata : $urandom;
            axi.r_id     = 4'($urandom);
            axi.r_last   = 1'b1;

            if (!rst_n) begin
                busy = 0;
                last_rdata = '0;
            end else begin
                if (axi.aw_valid && axi.aw_ready) begin n_aw++; hs_aw_addr = axi.aw_addr; q_order.push_back(1'b1); end
                if (axi.w_valid && axi.w_ready)   begin n_w++;  hs_w_data  = axi.w_data; end
                if (axi.ar_valid && axi.ar_ready) begin n_ar++; hs_ar_addr = axi.ar_addr; q_order.push_back(1'b0); end
                if (axi.b_valid && axi.b_ready)   n_b++;
                if (axi.r_valid && axi.r_ready)   n_r++;

                if (e_pready) begin
                    busy = 0;
                end else if (busy && wr) begin
                    if (!aw_done) begin if (axi.aw_valid && axi.aw_ready) aw_done = 1; else c_aw++; end
                    if (!w_done)  begin if (axi.w_valid && axi.w_ready) w_done = 1; else c_w++; end
                    if (b_phase)  begin if (axi.b_valid && axi.b_ready) rsp_done = 1; else c_b++; end
                end else if (busy) begin
                    if (!ar_done) begin if (axi.ar_valid && axi.ar_ready) ar_done = 1; else c_ar++; end
                    if (r_phase) begin
                        if (axi.r_valid && axi.r_ready) begin rsp_done = 1; last_rdata = m_rdata; end
                        else c_r++;
                    end
                end else if (psel && !penable) begin
                    busy = 1; wr = pwrite;
                    m_addr = paddr & 32'hFFFF_FFFC; m_wdata = pwdata;
                    aw_done = 0; w_done = 0; ar_done = 0; rsp_done = 0;
                    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
                    d_aw = t_aw; d_w = t_w; d_b = t_b; d_ar = t_ar; d_r = t_r;
                    m_resp = t_resp; m_rdata = t_rdata;
                end
            end
        end
    end

    // One APB transfer; inputs change 2 time units after the rising edge.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit drop,
                            output logic [31:0] rd, output bit slv, output int acc);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #2;
        penable = 1; acc = 1;
        if (drop) psel = 0;
        while (pready !== 1'b1 && acc < 300) begin
            @(posedge clk); #2;
            acc++;
        end
        if (pready !== 1'b1) chk("pready_timeout", 64'(pready), 64'(1));
        rd = prdata; slv = pslverr;
        @(posedge clk); #2;
        psel = 0; penable = 0;
    endtask

    task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int daw, input int dw, input int db, input int dar, input int dr,
                       input logic [1:0] resp, input logic [31:0] rdv, input bit drop,
                       output logic [31:0] rd, output int acc);
        bit slv;
        int exp_acc;
        t_aw = daw; t_w = dw; t_b = db; t_ar = dar; t_r = dr; t_resp = resp; t_rdata = rdv;
        apb_xfer(wr, addr, data, drop, rd, slv, acc);
        exp_acc = wr ? 3 + (daw > dw ? daw : dw) + db : 3 + dar + dr;
        chk("access_len", 64'(acc), 64'(exp_acc));
        if (!wr) chk("read_data", 64'(rd), 64'(rdv));
        chk("xfer_pslverr", 64'(slv), 64'(slverr_of(resp)));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        int          acc, nb0;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        t_aw = 0; t_w = 0; t_b = 0; t_ar = 0; t_r = 0; t_resp = 0; t_rdata = 0; force_stray = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #2;

        // Zero-wait write.
        run(1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, rd, acc);
        chk("wr_aw_addr", 64'(hs_aw_addr), 64'h104);
        chk("wr_w_data", 64'(hs_w_data), 64'hDEAD_BEEF);
        chk("wr_access3", 64'(acc), 64'd3);

        // Read with five r_valid=0 cycles.
        run(0, 32'h0000_0106, 32'h0, 0, 0, 0, 0, 5, 2'b00, 32'h1234_5678, 0, rd, acc);
        chk("rd_ar_addr", 64'(hs_ar_addr), 64'h104);
        chk("rd_prdata", 64'(rd), 64'h1234_5678);
        chk("rd_access8", 64'(acc), 64'd8);

        // aw_ready delayed 3 cycles, w_ready immediate.
        nb0 = n_b;
        run(1, 32'h0000_0200, 32'hA5A5_0001, 3, 0, 0, 0, 0, 2'b00, 32'h0, 0, rd, acc);
        chk("aw_delay_access6", 64'(acc), 64'd6);
        chk("aw_delay_one_b", 64'(n_b - nb0), 64'd1);

        // SLVERR on a read.
        run(0, 32'h0000_0040, 32'h0, 0, 0, 0, 1, 0, 2'b10, 32'hCAFE_0042, 0, rd, acc);
        chk("slverr_prdata", 64'(rd), 64'hCAFE_0042);

        // psel dropped during the access phase; the AXI side still finishes.
        run(1, 32'h0000_0300, 32'h0BAD_F00D, 1, 2, 1, 0, 0, 2'b11, 32'h0, 1, rd, acc);

        // Reset while waiting for the write response, then stray responses.
        t_aw = 0; t_w = 0; t_b = 20; t_ar = 0; t_r = 0; t_resp = 0;
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h80; pwdata = 32'h55;
        @(posedge clk); #2;
        penable = 1;
        for (int k = 0; k < 10 && axi.b_ready !== 1'b1; k++) begin
            @(posedge clk); #2;
        end
        chk("reach_wr_resp", 64'(axi.b_ready), 64'd1);
        rst_n = 0; psel = 0; penable = 0;
        @(posedge clk); #2;
        chk("rst_ctrl", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, pready, pslverr}), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);
        rst_n = 1; force_stray = 1; nb0 = n_b;
        repeat (4) begin
            @(posedge clk); #2;
            chk("stray_b_ready", 64'(axi.b_ready), 64'd0);
        end
        chk("stray_b_not_taken", 64'(n_b - nb0), 64'd0);
        force_stray = 0;

        // Back-to-back write then read to 0x0.
        q_order.delete();
        run(1, 32'h0, 32'h1111_2222, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, rd, acc);
        chk("b2b_wr_access", 64'(acc), 64'd3);
        run(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h3333_4444, 0, rd, acc);
        chk("b2b_rd_access", 64'(acc), 64'd3);
        chk("b2b_count", 64'(q_order.size()), 64'd2);
        if (q_order.size() == 2) begin
            chk("b2b_first_is_write", 64'(q_order[0]), 64'd1);
            chk("b2b_second_is_read", 64'(q_order[1]), 64'd0);
        end

        // Randomized transfers with random latencies, responses and gaps.
        for (int i = 0; i < 80; i++) begin
            run(1'($urandom), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom), $urandom, ($urandom_range(0, 7) == 0), rd, acc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
